regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: the ALU result path and the memory-load result path.
- Tracks in-flight destination registers in a scoreboard so the issue/decode stage can stall on RAW hazards.
- Sits between the execute/memory stages and the register file write port (reg_write_en / reg_write_dest / reg_write_data).

---
 rtl/regfile_write_arbiter_pkg.sv | 17 +
 rtl/regfile_write_arbiter_if.sv | 48 ++++
 rtl/regfile_write_arbiter_rr_arbiter_2.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 tb/tb_regfile_write_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Imported by the interface, the round-robin arbiter and the top level.
package regfile_write_arbiter_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, scoreboard claim and register-file write bundle.
// The arbiter uses the slave side; the requesters/issue stage use the master side.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = regfile_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W   = regfile_write_arbiter_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_write_arbiter_pkg::NUM_REGS
);

  logic                alu_wr_valid;
  logic                alu_wr_ready;
  logic [ADDR_W-1:0]   alu_wr_dest;
  logic [DATA_W-1:0]   alu_wr_data;

  logic                mem_wr_valid;
  logic                mem_wr_ready;
  logic [ADDR_W-1:0]   mem_wr_dest;
  logic [DATA_W-1:0]   mem_wr_data;

  logic                claim_en;
  logic [ADDR_W-1:0]   claim_dest;

  logic                reg_write_en;
  logic [ADDR_W-1:0]   reg_write_dest;
  logic [DATA_W-1:0]   reg_write_data;
  logic [NUM_REGS-1:0] busy_mask;
  logic                claim_conflict;

  modport master (
    output alu_wr_valid, alu_wr_dest, alu_wr_data,
    output mem_wr_valid, mem_wr_dest, mem_wr_data,
    output claim_en, claim_dest,
    input  alu_wr_ready, mem_wr_ready,
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  busy_mask, claim_conflict
  );

  modport slave (
    input  alu_wr_valid, alu_wr_dest, alu_wr_data,
    input  mem_wr_valid, mem_wr_dest, mem_wr_data,
    input  claim_en, claim_dest,
    output alu_wr_ready, mem_wr_ready,
    output reg_write_en, reg_write_dest, reg_write_data,
    output busy_mask, claim_conflict
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter_2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer
// advanced only when the caller reports that a grant was consumed.
module rr_arbiter_2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  rr_ptr_e r_ptr;

  // Grants are held low during reset so no handshake can complete.
  always_comb begin
    o_grant = 2'b00;
    if (rst) begin
      if (i_req[REQ_ALU] && (!i_req[REQ_MEM] || r_ptr == PRI_ALU)) begin
        o_grant[REQ_ALU] = 1'b1;
      end else if (i_req[REQ_MEM]) begin
        o_grant[REQ_MEM] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= PRI_ALU;
    end else if (i_advance) begin
      r_ptr <= o_grant[REQ_ALU] ? PRI_MEM : PRI_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback and
// keeps a busy scoreboard of destinations with writes still in flight.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = regfile_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W   = regfile_write_arbiter_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_write_arbiter_pkg::NUM_REGS
)(
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave bus
);

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_dest;
  logic [DATA_W-1:0]   w_data;
  logic                w_claim;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_wen;
  logic [ADDR_W-1:0]   r_dest;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_conflict;

  always_comb begin
    w_req          = 2'b00;
    w_req[REQ_ALU] = bus.alu_wr_valid;
    w_req[REQ_MEM] = bus.mem_wr_valid;
  end

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_xfer),
    .o_grant   (w_grant)
  );

  assign w_xfer = |w_grant;
  assign w_dest = w_grant[REQ_MEM] ? bus.mem_wr_dest : bus.alu_wr_dest;
  assign w_data = w_grant[REQ_MEM] ? bus.mem_wr_data : bus.alu_wr_data;

  assign w_claim = bus.claim_en && (bus.claim_dest != '0);

  // A same-cycle claim overrides the clear: the claimer is a newer producer.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_set[i] = w_claim && (bus.claim_dest == ADDR_W'(i));
      w_clr[i] = r_wen && (r_dest == ADDR_W'(i));
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  // Output register stage: one write per cycle, r0 writes are swallowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen      <= 1'b0;
      r_dest     <= '0;
      r_data     <= '0;
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_wen <= w_xfer && (w_dest != '0);
      if (w_xfer) begin
        r_dest <= w_dest;
        r_data <= w_data;
      end
      r_busy     <= w_busy_nxt;
      r_conflict <= |(r_busy & w_set);
    end
  end

  assign bus.alu_wr_ready   = w_grant[REQ_ALU];
  assign bus.mem_wr_ready   = w_grant[REQ_MEM];
  assign bus.reg_write_en   = r_wen;
  assign bus.reg_write_dest = r_dest;
  assign bus.reg_write_data = r_data;
  assign bus.busy_mask      = r_busy;
  assign bus.claim_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table with a write scoreboard,
// then hand-written scoreboard, collision, r0 and async-reset sequences.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  typedef struct {
    logic        av;
    logic [2:0]  ad;
    logic [15:0] adat;
    logic        mv;
    logic [2:0]  md;
    logic [15:0] mdat;
    logic        er;
    logic        em;
  } vec_t;

  typedef struct {
    logic        en;
    logic [2:0]  d;
    logic [15:0] dat;
  } wr_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vt[12];
  wr_t  exp_q[$];

  regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) bus ();

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_wr_valid = 1'b0;
    bus.alu_wr_dest  = '0;
    bus.alu_wr_data  = '0;
    bus.mem_wr_valid = 1'b0;
    bus.mem_wr_dest  = '0;
    bus.mem_wr_data  = '0;
    bus.claim_en     = 1'b0;
    bus.claim_dest   = '0;
  endtask

  function automatic vec_t mk(logic av, logic [2:0] ad, logic [15:0] adat,
                              logic mv, logic [2:0] md, logic [15:0] mdat,
                              logic er, logic em);
    vec_t v;
    v.av = av; v.ad = ad; v.adat = adat;
    v.mv = mv; v.md = md; v.mdat = mdat;
    v.er = er; v.em = em;
    return v;
  endfunction

  initial begin
    wr_t e;
    total = 0;
    bad   = 0;
    // Expected readies follow the round-robin pointer starting at ALU.
    vt[0]  = mk(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 1, 0);
    vt[1]  = mk(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 1);
    vt[2]  = mk(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 1, 0);
    vt[3]  = mk(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 0);
    vt[4]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);
    vt[5]  = mk(0, 3'd0, 16'h0000, 1, 3'd6, 16'hBEEF, 0, 1);
    vt[6]  = mk(1, 3'd7, 16'h0707, 1, 3'd1, 16'h1111, 1, 0);
    vt[7]  = mk(1, 3'd0, 16'hFFFF, 1, 3'd1, 16'h1111, 0, 1);
    vt[8]  = mk(1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0000, 1, 0);
    vt[9]  = mk(1, 3'd2, 16'h2222, 1, 3'd3, 16'h3333, 0, 1);
    vt[10] = mk(1, 3'd2, 16'h2222, 0, 3'd0, 16'h0000, 1, 0);
    vt[11] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);

    // Reset state, with a request pending to show ready is gated.
    rst = 1'b0;
    idle();
    #2;
    bus.alu_wr_valid = 1'b1;
    #1;
    chk("rst_alu_ready", 32'(bus.alu_wr_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_wr_ready), 32'd0);
    chk("rst_wen", 32'(bus.reg_write_en), 32'd0);
    chk("rst_dest", 32'(bus.reg_write_dest), 32'd0);
    chk("rst_data", 32'(bus.reg_write_data), 32'd0);
    chk("rst_busy", 32'(bus.busy_mask), 32'd0);
    chk("rst_conflict", 32'(bus.claim_conflict), 32'd0);
    idle();
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.alu_wr_valid = vt[i].av;
      bus.alu_wr_dest  = vt[i].ad;
      bus.alu_wr_data  = vt[i].adat;
      bus.mem_wr_valid = vt[i].mv;
      bus.mem_wr_dest  = vt[i].md;
      bus.mem_wr_data  = vt[i].mdat;
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(bus.alu_wr_ready), 32'(vt[i].er));
      chk($sformatf("v%0d_mem_ready", i), 32'(bus.mem_wr_ready), 32'(vt[i].em));
      e.en = 1'b0; e.d = '0; e.dat = '0;
      if (vt[i].er) begin
        e.en = (vt[i].ad != 3'd0); e.d = vt[i].ad; e.dat = vt[i].adat;
      end else if (vt[i].em) begin
        e.en = (vt[i].md != 3'd0); e.d = vt[i].md; e.dat = vt[i].mdat;
      end
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_wen", i), 32'(bus.reg_write_en), 32'(e.en));
      if (e.en) begin
        chk($sformatf("v%0d_dest", i), 32'(bus.reg_write_dest), 32'(e.d));
        chk($sformatf("v%0d_data", i), 32'(bus.reg_write_data), 32'(e.dat));
      end
    end
    idle();
    tick();

    // Claim 5, load writes 5 in cycle 3, bit clears after the commit cycle.
    bus.claim_en = 1'b1; bus.claim_dest = 3'd5;
    tick();
    idle();
    chk("sb_busy_set", 32'(bus.busy_mask), 32'h20);
    chk("sb_no_conflict", 32'(bus.claim_conflict), 32'd0);
    tick();
    tick();
    bus.mem_wr_valid = 1'b1; bus.mem_wr_dest = 3'd5; bus.mem_wr_data = 16'h5A5A;
    #1;
    chk("sb_mem_ready", 32'(bus.mem_wr_ready), 32'd1);
    tick();
    idle();
    chk("sb_wen", 32'(bus.reg_write_en), 32'd1);
    chk("sb_dest", 32'(bus.reg_write_dest), 32'd5);
    chk("sb_data", 32'(bus.reg_write_data), 32'h5A5A);
    chk("sb_busy_hold", 32'(bus.busy_mask), 32'h20);
    tick();
    chk("sb_busy_clear", 32'(bus.busy_mask), 32'h00);
    chk("sb_wen_off", 32'(bus.reg_write_en), 32'd0);

    // Claim and clear of register 4 in the same cycle.
    bus.claim_en = 1'b1; bus.claim_dest = 3'd4;
    tick();
    idle();
    chk("cc_busy_set", 32'(bus.busy_mask), 32'h10);
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 3'd4; bus.alu_wr_data = 16'h4444;
    #1;
    chk("cc_alu_ready", 32'(bus.alu_wr_ready), 32'd1);
    tick();
    idle();
    chk("cc_wen", 32'(bus.reg_write_en), 32'd1);
    chk("cc_dest", 32'(bus.reg_write_dest), 32'd4);
    bus.claim_en = 1'b1; bus.claim_dest = 3'd4;
    tick();
    idle();
    chk("cc_busy_kept", 32'(bus.busy_mask), 32'h10);
    chk("cc_conflict", 32'(bus.claim_conflict), 32'd1);
    tick();
    chk("cc_conflict_pulse", 32'(bus.claim_conflict), 32'd0);
    chk("cc_busy_still", 32'(bus.busy_mask), 32'h10);

    // r0: write accepted but dropped, claim ignored.
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 3'd0; bus.alu_wr_data = 16'hFFFF;
    bus.claim_en = 1'b1; bus.claim_dest = 3'd0;
    #1;
    chk("r0_ready", 32'(bus.alu_wr_ready), 32'd1);
    tick();
    idle();
    chk("r0_wen", 32'(bus.reg_write_en), 32'd0);
    chk("r0_busy", 32'(bus.busy_mask), 32'h10);
    chk("r0_conflict", 32'(bus.claim_conflict), 32'd0);

    // Build busy=0x0C with a write pending, then reset asynchronously.
    bus.claim_en = 1'b1; bus.claim_dest = 3'd2;
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 3'd4; bus.alu_wr_data = 16'h0404;
    tick();
    idle();
    bus.claim_en = 1'b1; bus.claim_dest = 3'd3;
    tick();
    idle();
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 3'd1; bus.alu_wr_data = 16'h1111;
    tick();
    idle();
    chk("ar_busy_pre", 32'(bus.busy_mask), 32'h0C);
    chk("ar_wen_pre", 32'(bus.reg_write_en), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_wen", 32'(bus.reg_write_en), 32'd0);
    chk("ar_dest", 32'(bus.reg_write_dest), 32'd0);
    chk("ar_data", 32'(bus.reg_write_data), 32'd0);
    chk("ar_busy", 32'(bus.busy_mask), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 3'd1; bus.alu_wr_data = 16'hA1A1;
    bus.mem_wr_valid = 1'b1; bus.mem_wr_dest = 3'd2; bus.mem_wr_data = 16'hB2B2;
    #1;
    chk("ar_first_alu", 32'(bus.alu_wr_ready), 32'd1);
    chk("ar_first_mem", 32'(bus.mem_wr_ready), 32'd0);
    tick();
    idle();
    chk("ar_post_wen", 32'(bus.reg_write_en), 32'd1);
    chk("ar_post_dest", 32'(bus.reg_write_dest), 32'd1);
    chk("ar_post_data", 32'(bus.reg_write_data), 32'hA1A1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
